// File: rtl/morra_cinese_fsmd_if.sv
// Round/match bus for the Morra Cinese referee.
// PRIMO/SECONDO : player moves (or match-length code while INIZIA=1)
// INIZIA        : start/restart a match
// MANCHE        : registered round result
// PARTITA       : registered match result
interface morra_cinese_fsmd_if;
  logic [1:0] PRIMO;
  logic [1:0] SECONDO;
  logic       INIZIA;
  logic [1:0] MANCHE;
  logic [1:0] PARTITA;

  // Player/controller side: drives moves and start, observes results.
  modport master (
    output PRIMO,
    output SECONDO,
    output INIZIA,
    input  MANCHE,
    input  PARTITA
  );

  // Referee side.
  modport slave (
    input  PRIMO,
    input  SECONDO,
    input  INIZIA,
    output MANCHE,
    output PARTITA
  );
endinterface

// File: rtl/morra_cinese_fsmd.sv
// Morra Cinese (rock-paper-scissors) match referee: FSM plus counters.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave modport: PRIMO/SECONDO/INIZIA in, MANCHE/PARTITA out
// Move codes: 00 invalid, 01 rock, 10 paper, 11 scissors.
// Result codes: 00 none/invalid, 01 P1, 10 P2, 11 draw.
module morra_cinese_fsmd (
  input  logic                 clk,
  input  logic                 rst,
  morra_cinese_fsmd_if.slave   bus
);

  localparam int unsigned CNT_W  = 5;
  localparam int unsigned MOVE_W = 2;

  localparam logic [MOVE_W-1:0] MOVE_NONE = 2'b00;
  localparam logic [MOVE_W-1:0] MOVE_ROCK = 2'b01;
  localparam logic [MOVE_W-1:0] MOVE_PAP  = 2'b10;
  localparam logic [MOVE_W-1:0] MOVE_SCI  = 2'b11;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_P1   = 2'b01;
  localparam logic [1:0] RES_P2   = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    OVER = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10
  } win_t;

  state_t             state_q,    state_d;
  logic [CNT_W-1:0]   max_q,      max_d;
  logic [CNT_W-1:0]   w1_q,       w1_d;
  logic [CNT_W-1:0]   w2_q,       w2_d;
  logic [CNT_W-1:0]   played_q,   played_d;
  win_t               lastwin_q,  lastwin_d;
  logic [MOVE_W-1:0]  lastmove_q, lastmove_d;
  logic [1:0]         manche_q,   manche_d;
  logic [1:0]         partita_q,  partita_d;

  // Round evaluation helpers
  logic               round_bad;
  logic               p1_beats;
  logic [CNT_W-1:0]   w1_n, w2_n, played_n, diff_n;
  logic               match_end;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      max_q      <= '0;
      w1_q       <= '0;
      w2_q       <= '0;
      played_q   <= '0;
      lastwin_q  <= WIN_NONE;
      lastmove_q <= MOVE_NONE;
      manche_q   <= RES_NONE;
      partita_q  <= RES_NONE;
    end else begin
      state_q    <= state_d;
      max_q      <= max_d;
      w1_q       <= w1_d;
      w2_q       <= w2_d;
      played_q   <= played_d;
      lastwin_q  <= lastwin_d;
      lastmove_q <= lastmove_d;
      manche_q   <= manche_d;
      partita_q  <= partita_d;
    end
  end

  // Next-state, datapath update and result encoding
  always_comb begin
    state_d    = state_q;
    max_d      = max_q;
    w1_d       = w1_q;
    w2_d       = w2_q;
    played_d   = played_q;
    lastwin_d  = lastwin_q;
    lastmove_d = lastmove_q;
    manche_d   = RES_NONE;
    partita_d  = RES_NONE;

    // Invalid if a move is missing or the last winner reuses the winning move
    round_bad  = (bus.PRIMO == MOVE_NONE) || (bus.SECONDO == MOVE_NONE) ||
                 ((lastwin_q == WIN_P1) && (bus.PRIMO   == lastmove_q)) ||
                 ((lastwin_q == WIN_P2) && (bus.SECONDO == lastmove_q));

    p1_beats   = ((bus.PRIMO == MOVE_ROCK) && (bus.SECONDO == MOVE_SCI))  ||
                 ((bus.PRIMO == MOVE_SCI)  && (bus.SECONDO == MOVE_PAP))  ||
                 ((bus.PRIMO == MOVE_PAP)  && (bus.SECONDO == MOVE_ROCK));

    played_n   = played_q + CNT_W'(1);
    w1_n       = w1_q;
    w2_n       = w2_q;
    if (bus.PRIMO != bus.SECONDO) begin
      if (p1_beats) w1_n = w1_q + CNT_W'(1);
      else          w2_n = w2_q + CNT_W'(1);
    end

    diff_n     = (w1_n >= w2_n) ? (w1_n - w2_n) : (w2_n - w1_n);
    match_end  = (played_n == max_q) ||
                 ((played_n >= CNT_W'(4)) && (diff_n >= CNT_W'(2)));

    if (bus.INIZIA) begin
      // Start/restart wins over everything; moves carry the length code
      max_d      = CNT_W'({bus.PRIMO, bus.SECONDO}) + CNT_W'(4);
      w1_d       = '0;
      w2_d       = '0;
      played_d   = '0;
      lastwin_d  = WIN_NONE;
      lastmove_d = MOVE_NONE;
      state_d    = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (!round_bad) begin
            played_d = played_n;
            w1_d     = w1_n;
            w2_d     = w2_n;
            if (bus.PRIMO == bus.SECONDO) begin
              manche_d  = RES_DRAW;
              lastwin_d = WIN_NONE;
            end else if (p1_beats) begin
              manche_d   = RES_P1;
              lastwin_d  = WIN_P1;
              lastmove_d = bus.PRIMO;
            end else begin
              manche_d   = RES_P2;
              lastwin_d  = WIN_P2;
              lastmove_d = bus.SECONDO;
            end
            if (match_end) begin
              state_d = OVER;
              if (w1_n > w2_n)      partita_d = RES_P1;
              else if (w2_n > w1_n) partita_d = RES_P2;
              else                  partita_d = RES_DRAW;
            end
          end
        end
        IDLE:    state_d = IDLE;
        OVER:    state_d = OVER;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.MANCHE  = manche_q;
  assign bus.PARTITA = partita_q;

endmodule

// File: tb/tb_morra_cinese_fsmd.sv
// Directed bench for the Morra Cinese referee.
module tb_morra_cinese_fsmd;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  morra_cinese_fsmd_if bus();

  morra_cinese_fsmd dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then check both registered outputs
  task automatic cyc(input string tag, input logic ini, input logic [1:0] a,
                     input logic [1:0] b, input logic [1:0] em, input logic [1:0] ep);
    @(negedge clk);
    bus.INIZIA  = ini;
    bus.PRIMO   = a;
    bus.SECONDO = b;
    @(posedge clk);
    #1;
    check({tag, "_manche"},  bus.MANCHE,  em);
    check({tag, "_partita"}, bus.PARTITA, ep);
  endtask

  task automatic start(input string tag, input logic [1:0] a, input logic [1:0] b);
    cyc(tag, 1'b1, a, b, 2'b00, 2'b00);
  endtask

  task automatic round(input string tag, input logic [1:0] a, input logic [1:0] b,
                       input logic [1:0] em, input logic [1:0] ep);
    cyc(tag, 1'b0, a, b, em, ep);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.INIZIA  = 1'b0;
    bus.PRIMO   = 2'b00;
    bus.SECONDO = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    check("reset_manche",  bus.MANCHE,  2'b00);
    check("reset_partita", bus.PARTITA, 2'b00);
    @(negedge clk);
    rst = 1'b0;

    // IDLE ignores moves
    round("idle0", 2'b01, 2'b11, 2'b00, 2'b00);
    round("idle1", 2'b10, 2'b01, 2'b00, 2'b00);

    // Length 4: ends 1-1 on played=4
    start("l4_start", 2'b00, 2'b00);
    round("l4_r1", 2'b01, 2'b10, 2'b10, 2'b00);
    round("l4_r2", 2'b01, 2'b11, 2'b01, 2'b00);
    round("l4_r3", 2'b10, 2'b10, 2'b11, 2'b00);
    round("l4_r4", 2'b11, 2'b11, 2'b11, 2'b11);

    // Length 6. P2 wins twice with scissors-then-paper; the 11/10 round
    // has P2 reusing winning paper so it is rejected, leaving 0-2, and the
    // second draw reaches played=4 with a 2-point gap: P2 takes the match.
    start("l6_start", 2'b00, 2'b10);
    round("l6_r1",  2'b10, 2'b11, 2'b10, 2'b00);
    round("l6_r2",  2'b10, 2'b11, 2'b00, 2'b00);
    round("l6_r3",  2'b10, 2'b00, 2'b00, 2'b00);
    round("l6_r4",  2'b00, 2'b10, 2'b00, 2'b00);
    round("l6_r5",  2'b10, 2'b11, 2'b00, 2'b00);
    round("l6_r6",  2'b01, 2'b10, 2'b10, 2'b00);
    round("l6_r7",  2'b11, 2'b10, 2'b00, 2'b00);
    round("l6_r8",  2'b01, 2'b01, 2'b11, 2'b00);
    round("l6_r9",  2'b11, 2'b11, 2'b11, 2'b10);
    round("l6_r10", 2'b01, 2'b11, 2'b00, 2'b00);

    // Early finish at played=5, P1 3-1
    start("ef_start", 2'b00, 2'b10);
    round("ef_r1", 2'b11, 2'b10, 2'b01, 2'b00);
    round("ef_r2", 2'b01, 2'b01, 2'b11, 2'b00);
    round("ef_r3", 2'b01, 2'b10, 2'b10, 2'b00);
    round("ef_r4", 2'b10, 2'b01, 2'b01, 2'b00);
    round("ef_r5", 2'b10, 2'b11, 2'b00, 2'b00);
    round("ef_r6", 2'b11, 2'b10, 2'b01, 2'b01);

    // OVER holds
    for (int i = 0; i < 3; i++)
      round($sformatf("over_hold%0d", i), 2'b01, 2'b11, 2'b00, 2'b00);

    // New match, then restart mid-match must clear the restriction
    start("rs_start", 2'b00, 2'b00);
    round("rs_r1", 2'b01, 2'b11, 2'b01, 2'b00);
    start("rs_restart", 2'b00, 2'b00);
    round("rs_r2", 2'b01, 2'b11, 2'b01, 2'b00);

    // Asynchronous reset mid-match
    start("ar_start", 2'b00, 2'b10);
    round("ar_r1", 2'b11, 2'b10, 2'b01, 2'b00);
    round("ar_r2", 2'b01, 2'b01, 2'b11, 2'b00);
    @(negedge clk);
    bus.PRIMO   = 2'b01;
    bus.SECONDO = 2'b11;
    rst = 1'b1;
    #1;
    check("ar_async_manche",  bus.MANCHE,  2'b00);
    check("ar_async_partita", bus.PARTITA, 2'b00);
    @(negedge clk);
    rst = 1'b0;
    round("ar_idle0", 2'b01, 2'b11, 2'b00, 2'b00);
    round("ar_idle1", 2'b10, 2'b01, 2'b00, 2'b00);

    // Max length 19: alternate wins keep the gap at most 1
    start("mx_start", 2'b11, 2'b11);
    for (int i = 0; i < 18; i++) begin
      if (i % 2 == 0)
        round($sformatf("mx_r%0d", i + 1), 2'b01, 2'b11, 2'b01, 2'b00);
      else
        round($sformatf("mx_r%0d", i + 1), 2'b11, 2'b01, 2'b10, 2'b00);
    end
    round("mx_r19", 2'b10, 2'b10, 2'b11, 2'b11);
    round("mx_over", 2'b01, 2'b11, 2'b00, 2'b00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
